// File: rtl/dot_product_mac_pkg.sv
// -----------------------------------------------------------------------------
// dot_pkg
// Shared definitions for the streaming dot-product engine: the controller
// state encoding, default operand/vector/result sizes, and the helper that
// derives an accumulator width wide enough that a full vector of maximum
// products can never wrap.
// -----------------------------------------------------------------------------
package dot_pkg;

   // Controller states: accept pairs, fold in the last product, hold result
   typedef enum logic [1:0] {
      ST_ACC   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } dot_state_e;

   localparam int DOT_DATA_W = 8;
   localparam int DOT_N_ELEM = 8;
   localparam int DOT_OUT_W  = 8;

   // Each product needs 2*dataW bits; summing nElem of them adds clog2(nElem)
   function automatic int acc_width(input int dataW, input int nElem);
      return 2 * dataW + $clog2(nElem);
   endfunction

endpackage

// File: rtl/dot_product_mac_if.sv
// -----------------------------------------------------------------------------
// dot_product_mac_if
// Bundles the operand stream (in_valid/in_ready/in_x/in_w) and the result
// channel (out_valid/out_ready/out_data/out_acc/out_ovf) of the dot-product
// engine.
//   master : the producer/consumer side (drives operands and out_ready)
//   slave  : the engine side (drives in_ready and the result)
// Parameters DATA_W, ACC_W and OUT_W must match those of the engine.
// -----------------------------------------------------------------------------
interface dot_product_mac_if
   import dot_pkg::*;
#(
   parameter int DATA_W = DOT_DATA_W,
   parameter int ACC_W  = acc_width(DOT_DATA_W, DOT_N_ELEM),
   parameter int OUT_W  = DOT_OUT_W
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_x;
   logic [DATA_W-1:0] in_w;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;
   logic [ACC_W-1:0]  out_acc;
   logic              out_ovf;

   modport master (
      output in_valid, in_x, in_w, out_ready,
      input  in_ready, out_valid, out_data, out_acc, out_ovf
   );

   modport slave (
      input  in_valid, in_x, in_w, out_ready,
      output in_ready, out_valid, out_data, out_acc, out_ovf
   );

endinterface

// File: rtl/dot_product_mac_stage.sv
// -----------------------------------------------------------------------------
// dot_mac_stage
// Two-step multiply-accumulate datapath. A loaded pair is multiplied into a
// product register; on the following cycle the registered product is added
// into the accumulator. acc_next_o exposes the sum including any pending
// product so the controller can capture the final total in the same cycle
// the last product is folded in.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : capture x_i*w_i into the product register
//   clr_i       : drop the pending product and zero the accumulator
//   x_i, w_i    : unsigned operands
//   acc_next_o  : accumulator value after the pending product is added
// -----------------------------------------------------------------------------
module dot_mac_stage
   import dot_pkg::*;
#(
   parameter int DATA_W = DOT_DATA_W,
   parameter int ACC_W  = acc_width(DOT_DATA_W, DOT_N_ELEM)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              clr_i,
   input  logic [DATA_W-1:0] x_i,
   input  logic [DATA_W-1:0] w_i,
   output logic [ACC_W-1:0]  acc_next_o
);

   logic [2*DATA_W-1:0] prod_q, prod_d;
   logic                prodV_q, prodV_d;
   logic [ACC_W-1:0]    acc_q, acc_d;

   // A product only counts on the cycle right after its pair was loaded, so
   // stalls in the operand stream never re-add a stale product.
   assign acc_next_o = prodV_q ? acc_q + ACC_W'(prod_q) : acc_q;

   // Next-state for the product pipeline and accumulator. Clearing wins over
   // accumulation; the product register itself is left alone since its valid
   // flag is what gates its use.
   always_comb begin
      prod_d  = prod_q;
      prodV_d = load_i;
      acc_d   = acc_next_o;
      if (load_i) begin
         prod_d = (2*DATA_W)'(x_i) * (2*DATA_W)'(w_i);
      end
      if (clr_i) begin
         prodV_d = 1'b0;
         acc_d   = '0;
      end
   end

   // Datapath registers; reset discards any partial vector immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q  <= '0;
         prodV_q <= 1'b0;
         acc_q   <= '0;
      end else begin
         prod_q  <= prod_d;
         prodV_q <= prodV_d;
         acc_q   <= acc_d;
      end
   end

endmodule

// File: rtl/dot_product_mac.sv
// -----------------------------------------------------------------------------
// dot_product_mac
// Streaming dot-product engine: accepts N_ELEM unsigned (x, w) pairs, one per
// cycle, and presents sum(x*w) at full precision together with an OUT_W-bit
// reduced value and an overflow flag. The result is held until taken.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous abort of the vector in progress
//   bus        : dot_product_mac_if slave (operand stream + result channel)
// Build option:
//   DOT_SAT_EN : when defined, out_data saturates to all ones on overflow;
//                otherwise it is the truncated low OUT_W bits of the sum.
// -----------------------------------------------------------------------------
module dot_product_mac
   import dot_pkg::*;
#(
   parameter int DATA_W = DOT_DATA_W,
   parameter int N_ELEM = DOT_N_ELEM,
   parameter int ACC_W  = acc_width(DATA_W, N_ELEM),
   parameter int OUT_W  = DOT_OUT_W
) (
   input logic              clk,
   input logic              rst_n,
   input logic              clear,
   dot_product_mac_if.slave bus
);

   localparam int              CNT_W    = $clog2(N_ELEM);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ELEM - 1);

   dot_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] outAcc_q, outAcc_d;
   logic [OUT_W-1:0] outData_q, outData_d;
   logic             outOvf_q, outOvf_d;

   logic             transfer;
   logic             outTaken;
   logic [ACC_W-1:0] accNext;
   logic             sumOvf;
   logic [OUT_W-1:0] sumData;

   assign bus.in_ready  = (state_q == ST_ACC);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.out_acc   = outAcc_q;
   assign bus.out_data  = outData_q;
   assign bus.out_ovf   = outOvf_q;

   // clear beats both a pair transfer and a result handshake in the same cycle
   assign transfer = bus.in_valid && (state_q == ST_ACC) && !clear;
   assign outTaken = bus.out_ready && (state_q == ST_DONE);

   dot_mac_stage #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (transfer),
      .clr_i      (clear || outTaken),
      .x_i        (bus.in_x),
      .w_i        (bus.in_w),
      .acc_next_o (accNext)
   );

   // Reduction of the final sum: any bit above OUT_W means it does not fit.
   assign sumOvf = |(accNext >> OUT_W);
`ifdef DOT_SAT_EN
   assign sumData = sumOvf ? {OUT_W{1'b1}} : accNext[OUT_W-1:0];
`else
   assign sumData = accNext[OUT_W-1:0];
`endif

   // Controller next-state. The counter wraps to zero on the last pair so the
   // next vector starts clean. The result registers load only in DRAIN, when
   // accNext already includes the last product; an abort leaves them intact.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      outAcc_d  = outAcc_q;
      outData_d = outData_q;
      outOvf_d  = outOvf_q;
      if (clear) begin
         state_d = ST_ACC;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_ACC: begin
               if (transfer) begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_d   = '0;
                     state_d = ST_DRAIN;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               state_d   = ST_DONE;
               outAcc_d  = accNext;
               outData_d = sumData;
               outOvf_d  = sumOvf;
            end
            ST_DONE: begin
               if (outTaken) begin
                  state_d = ST_ACC;
               end
            end
            default: state_d = ST_ACC;
         endcase
      end
   end

   // Controller and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ACC;
         cnt_q     <= '0;
         outAcc_q  <= '0;
         outData_q <= '0;
         outOvf_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         outAcc_q  <= outAcc_d;
         outData_q <= outData_d;
         outOvf_q  <= outOvf_d;
      end
   end

endmodule

// File: tb/tb_dot_product_mac.sv
// -----------------------------------------------------------------------------
// tb_dot_product_mac
// Drives two engines (default sizing, and DATA_W=4/N_ELEM=3). The stimulus
// side keeps a running arithmetic sum of the pairs the engine accepts and
// queues the expected total when a vector completes; independent monitors pop
// that queue whenever a result is handed over and compare all result fields.
// -----------------------------------------------------------------------------
module tb_dot_product_mac;
   import dot_pkg::*;

   localparam int DW  = 8;
   localparam int NE  = 8;
   localparam int OW  = 8;
   localparam int AW  = acc_width(DW, NE);
   localparam int SDW = 4;
   localparam int SNE = 3;
   localparam int SAW = acc_width(SDW, SNE);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic sClear = 1'b0;

   int     checks = 0;
   int     errors = 0;
   longint expQ[$];
   longint sExpQ[$];
   longint modelSum = 0;
   int     modelCnt = 0;
   bit     randReady = 1'b0;

   // Free-running clock, 10 time-unit period
   always #5 clk = ~clk;

   dot_product_mac_if #(.DATA_W(DW),  .ACC_W(AW),  .OUT_W(OW)) bus ();
   dot_product_mac_if #(.DATA_W(SDW), .ACC_W(SAW), .OUT_W(OW)) sBus ();

   dot_product_mac #(.DATA_W(DW), .N_ELEM(NE), .ACC_W(AW), .OUT_W(OW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (bus)
   );

   dot_product_mac #(.DATA_W(SDW), .N_ELEM(SNE), .ACC_W(SAW), .OUT_W(OW)) sDut (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (sClear),
      .bus   (sBus)
   );

   // Expected reduced value straight from the arithmetic rule
   function automatic longint expData(input longint acc, input int ow);
      longint maxVal;
      maxVal = (longint'(1) << ow) - 1;
`ifdef DOT_SAT_EN
      if (acc > maxVal) return maxVal;
`endif
      return acc & maxVal;
   endfunction

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor for the default engine: every handed-over result is checked
   always @(negedge clk) begin : monDefault
      longint e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected result", 1, 0);
         end else begin
            e = expQ.pop_front();
            checkOutput("out_acc", longint'(bus.out_acc), e);
            checkOutput("out_ovf", longint'(bus.out_ovf), (e > 255) ? 1 : 0);
            checkOutput("out_data", longint'(bus.out_data), expData(e, OW));
         end
      end
   end

   // Monitor for the small engine
   always @(negedge clk) begin : monSmall
      longint e;
      if (rst_n && sBus.out_valid && sBus.out_ready) begin
         if (sExpQ.size() == 0) begin
            checkOutput("small unexpected result", 1, 0);
         end else begin
            e = sExpQ.pop_front();
            checkOutput("small out_acc", longint'(sBus.out_acc), e);
            checkOutput("small out_ovf", longint'(sBus.out_ovf), (e > 255) ? 1 : 0);
            checkOutput("small out_data", longint'(sBus.out_data), expData(e, OW));
         end
      end
   end

   // One offer cycle: inputs set just after a rising edge, acceptance seen at
   // the falling edge, model updated after the edge that takes the pair.
   task automatic applyStimulus(input logic [DW-1:0] x, input logic [DW-1:0] w,
                                input bit clr, output bit accepted);
      bus.in_valid = 1'b1;
      bus.in_x     = x;
      bus.in_w     = w;
      clear        = clr;
      if (randReady) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      accepted = bus.in_ready && !clr;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      clear        = 1'b0;
      if (clr) begin
         modelSum = 0;
         modelCnt = 0;
      end else if (accepted) begin
         modelSum += longint'(x) * longint'(w);
         modelCnt++;
         if (modelCnt == NE) begin
            expQ.push_back(modelSum);
            modelSum = 0;
            modelCnt = 0;
         end
      end
   endtask

   task automatic sendPair(input logic [DW-1:0] x, input logic [DW-1:0] w);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) applyStimulus(x, w, 1'b0, ok);
      if (!ok) checkOutput("in_ready timeout", 0, 1);
   endtask

   task automatic waitResults(input int budget);
      int t;
      t = 0;
      while ((expQ.size() != 0 || sExpQ.size() != 0) && t < budget) begin
         if (randReady) bus.out_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         t++;
      end
      if (expQ.size() + sExpQ.size() != 0)
         checkOutput("result timeout", longint'(expQ.size() + sExpQ.size()), 0);
      @(posedge clk);
      #1;
   endtask

   // Main stimulus sequence
   initial begin : stim
      int  edges;
      bit  seen;
      int  sAccepted;
      longint sSum;

      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_w      = '0;
      bus.out_ready = 1'b1;
      sBus.in_valid  = 1'b0;
      sBus.in_x      = '0;
      sBus.in_w      = '0;
      sBus.out_ready = 1'b1;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset out_valid", longint'(bus.out_valid), 0);
      checkOutput("reset out_acc", longint'(bus.out_acc), 0);
      checkOutput("reset out_data", longint'(bus.out_data), 0);
      checkOutput("reset out_ovf", longint'(bus.out_ovf), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("in_ready after reset", longint'(bus.in_ready), 1);

      // Contiguous vector x=i+1, w=2 and result latency
      $display("[TB] contiguous vector");
      for (int i = 0; i < NE; i++) sendPair(DW'(i + 1), 8'd2);
      checkOutput("in_ready in drain", longint'(bus.in_ready), 0);
      edges = 1;
      seen  = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
         else begin
            @(posedge clk);
            edges++;
         end
      end
      checkOutput("latency edges incl accept", edges, 2);
      @(posedge clk);
      #1;
      waitResults(50);

      // Largest operands
      $display("[TB] 255*255 vector");
      for (int i = 0; i < NE; i++) sendPair(8'd255, 8'd255);
      waitResults(50);

      // Gapped input and a held result
      $display("[TB] gapped vector, held output");
      bus.out_ready = 1'b0;
      for (int i = 0; i < NE; i++) begin
         sendPair(DW'(i + 1), 8'd2);
         @(posedge clk);
         #1;
      end
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      checkOutput("held out_valid seen", longint'(seen), 1);
      for (int k = 0; k < 5; k++) begin
         checkOutput("held out_valid", longint'(bus.out_valid), 1);
         checkOutput("held out_acc", longint'(bus.out_acc), 72);
         checkOutput("held in_ready", longint'(bus.in_ready), 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      checkOutput("in_ready at handshake", longint'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      checkOutput("in_ready after handshake", longint'(bus.in_ready), 1);

      // Abort after four pairs; the aborting pair is dropped
      $display("[TB] clear mid-vector");
      for (int i = 0; i < 4; i++) sendPair(8'd3, 8'd5);
      applyStimulus(8'd9, 8'd9, 1'b1, seen);
      for (int i = 0; i < NE; i++) sendPair(8'd1, 8'd1);
      waitResults(50);

      // Asynchronous reset mid-vector
      $display("[TB] reset mid-vector");
      for (int i = 0; i < 5; i++) sendPair(8'd7, 8'd7);
      #2;
      rst_n = 1'b0;
      modelSum = 0;
      modelCnt = 0;
      #1;
      checkOutput("async reset out_valid", longint'(bus.out_valid), 0);
      checkOutput("async reset out_acc", longint'(bus.out_acc), 0);
      checkOutput("async reset out_data", longint'(bus.out_data), 0);
      checkOutput("async reset out_ovf", longint'(bus.out_ovf), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < NE; i++) sendPair(DW'(i + 2), 8'd3);
      waitResults(50);

      // Random vectors, random gaps, random consumer back-pressure
      $display("[TB] random vectors");
      randReady = 1'b1;
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < NE; i++) begin
            sendPair(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
         end
      end
      waitResults(300);
      randReady = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Small configuration: three pairs of 15*15
      $display("[TB] small configuration");
      sAccepted = 0;
      sSum = 0;
      sBus.in_x = 4'd15;
      sBus.in_w = 4'd15;
      for (int t = 0; t < 20 && sAccepted < SNE; t++) begin
         sBus.in_valid = 1'b1;
         @(negedge clk);
         if (sBus.in_ready) begin
            sAccepted++;
            sSum += 15 * 15;
         end
         @(posedge clk);
         #1;
      end
      sBus.in_valid = 1'b0;
      if (sAccepted == SNE) sExpQ.push_back(sSum);
      else checkOutput("small in_ready timeout", sAccepted, SNE);
      waitResults(50);

      checkOutput("default queue empty", longint'(expQ.size()), 0);
      checkOutput("small queue empty", longint'(sExpQ.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
